// File: rtl/jtkicker_psgq.sv
// jtkicker_psgq: CPU write queue feeding a PSG through a cs/wr/ready sequencer.
// Define JTKICKER_PSGQ_OVF_EN to enable the sticky overflow flag.
`timescale 1ns/1ps
module jtkicker_psgq #(
    parameter int AW   = 2,
    parameter int TOUT = 63
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cpu_cen,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       psg_cen,
    input  logic       psg_ready,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic       busy,
    output logic       ovf,
    input  logic       ovf_clr
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TOUT < 1) ? 1 : $clog2(TOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          empty, full, push, pop;
    state_t        state_q;
    logic          cs_n_q, wr_n_q;
    logic [7:0]    dout_q;
    logic [TW-1:0] tcnt_q;
    logic          seen_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = wr & cpu_cen & ~full;
    assign pop   = psg_cen & ~empty & (state_q == IDLE);

    assign wptr_d = wptr_q + (AW+1)'(push);
    assign rptr_d = rptr_q + (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // ready low is latched on any clk cycle, so short pulses between ticks count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            dout_q  <= '0;
            tcnt_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            if (state_q == WAIT && !psg_ready) seen_q <= 1'b1;
            if (psg_cen) begin
                unique case (state_q)
                    IDLE: begin
                        if (!empty) begin
                            dout_q  <= mem_q[rptr_q[AW-1:0]];
                            cs_n_q  <= 1'b0;
                            state_q <= SETUP;
                        end
                    end
                    SETUP: begin
                        wr_n_q  <= 1'b0;
                        state_q <= STROBE;
                    end
                    STROBE: begin
                        wr_n_q  <= 1'b1;
                        cs_n_q  <= 1'b1;
                        tcnt_q  <= '0;
                        seen_q  <= 1'b0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if ((seen_q && psg_ready) || tcnt_q == TW'(TOUT))
                            state_q <= IDLE;
                        else
                            tcnt_q <= tcnt_q + TW'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign psg_cs_n = cs_n_q;
    assign psg_wr_n = wr_n_q;
    assign psg_din  = dout_q;
    assign busy     = ~empty | (state_q != IDLE);

`ifdef JTKICKER_PSGQ_OVF_EN
    logic drop, ovf_q, ovf_d;

    assign drop = wr & cpu_cen & full;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/jtkicker_psgq.md
JTKICKER_PSGQ -- requirements
Module: jtkicker_psgq

Interface
REQ-001 SHALL have parameter AW, default 2: FIFO address width (depth = 2^AW entries).
REQ-002 SHALL have parameter TOUT, default 63: ready-wait timeout, counted in psg_cen ticks.
REQ-003 SHALL have port clk  in  1: system clock (24 MHz); the only clock.
REQ-004 SHALL have port rstn  in  1: reset, synchronous, active-low.
REQ-005 SHALL have port cpu_cen  in  1: CPU bus-cycle enable; qualifies wr.
REQ-006 SHALL have port wr  in  1: CPU write strobe to the PSG data port (decoded chip select AND NOT RnW).
REQ-007 SHALL have port din  in  8: CPU write data.
REQ-008 SHALL have port psg_cen  in  1: PSG clock enable (ti1_cen).
REQ-009 SHALL have port psg_ready  in  1: PSG ready; low while the PSG is absorbing a write.
REQ-010 SHALL have port psg_cs_n  out  1: PSG chip select, active-low.
REQ-011 SHALL have port psg_wr_n  out  1: PSG write strobe, active-low.
REQ-012 SHALL have port psg_din  out  8: data presented to the PSG.
REQ-013 SHALL have port busy  out  1: high when the FIFO is non-empty or the FSM is not IDLE.
REQ-014 SHALL have port ovf  out  1: sticky overflow flag.
REQ-015 SHALL have port ovf_clr  in  1: clears ovf.

Function
REQ-016 SHALL push din into the FIFO on a cycle where wr & cpu_cen & !full; a push is accepted exactly once per CPU cycle.
REQ-017 SHALL drop the push when the FIFO is full; the FIFO contents remain unchanged.
REQ-018 SHALL maintain AW+1-bit read/write pointers; wrap-around is modulo 2^AW; full = pointers differ only in the MSB; empty = pointers equal.
REQ-019 SHALL run FSM IDLE -> SETUP -> STROBE -> WAIT -> IDLE, advancing only on psg_cen ticks.
REQ-020 IDLE: on a psg_cen tick with the FIFO non-empty, SHALL load psg_din from the FIFO head, pop it, drive psg_cs_n=0, and go to SETUP.
REQ-021 SETUP: on the next psg_cen tick SHALL drive psg_wr_n=0 and go to STROBE.
REQ-022 STROBE: on the next psg_cen tick SHALL drive psg_wr_n=1 and psg_cs_n=1, clear the timeout counter, and go to WAIT.
REQ-023 WAIT: SHALL return to IDLE on a psg_cen tick with psg_ready=1 once psg_ready has been seen low; otherwise it SHALL return after TOUT+1 psg_cen ticks (timeout).
REQ-024 psg_din SHALL hold stable from SETUP entry until WAIT exit.
REQ-025 A simultaneous push and pop SHALL both take effect; occupancy is unchanged.
REQ-026 A push into an empty FIFO SHALL become visible to IDLE no earlier than the next clk cycle.
REQ-027 Minimum service time per byte SHALL be 3 psg_cen ticks plus the WAIT duration.
REQ-028 busy SHALL be combinational from the FIFO-empty flag and the FSM state.
REQ-029 ovf SHALL set on a dropped push and clear on ovf_clr; if both occur in the same cycle, set wins.

Reset
REQ-030 While rstn=0 at a clk edge: FSM=IDLE, pointers=0, psg_cs_n=1, psg_wr_n=1, psg_din=0, ovf=0, timeout counter=0.
REQ-031 Reset during any state SHALL abort the transfer and return the PSG strobes to inactive on the same edge; queued data SHALL be discarded.

Configuration
REQ-032 Macro JTKICKER_PSGQ_OVF_EN: when defined, ovf SHALL behave per REQ-029; when undefined, ovf SHALL be tied 0, ovf_clr ignored, and full-FIFO pushes still dropped silently.

Verification
REQ-033 Reset, then wr with din=8'h9F for one cpu_cen cycle -> psg_din=8'h9F, psg_cs_n low for 2 psg_cen ticks, psg_wr_n low for 1 tick, busy=0 after ready returns.
REQ-034 4 back-to-back writes 8'h80,8'h01,8'h90,8'h0F with ready pulsing low -> PSG receives the same order; each byte is strobed only after the previous ready high.
REQ-035 AW=2, psg_ready held low, 5 pushes -> fifth dropped; ovf=1 with JTKICKER_PSGQ_OVF_EN, 0 without; ovf_clr pulse -> ovf=0.
REQ-036 psg_ready stuck high (never falls) -> WAIT exits after 64 psg_cen ticks; next byte proceeds.
REQ-037 rstn low asserted during STROBE with 2 bytes queued -> psg_wr_n=1, psg_cs_n=1 on the next edge; busy=0; no further strobes after release.
REQ-038 Push coincident with IDLE pop at full-1 occupancy -> occupancy unchanged, no drop, ovf stays 0.
